// File: rtl/usb_fe_pkg.sv
// Shared FSM encoding and parameter limits for the host-bus register front-end.
package usb_fe_pkg;

   localparam logic [2:0] ENC_IDLE     = 3'd0;
   localparam logic [2:0] ENC_WR_HOLD  = 3'd1;
   localparam logic [2:0] ENC_RD_WAIT  = 3'd2;
   localparam logic [2:0] ENC_RD_HOLD  = 3'd3;
   localparam logic [2:0] ENC_ISO_TAIL = 3'd4;

   typedef enum logic [2:0] {
      ST_IDLE     = ENC_IDLE,
      ST_WR_HOLD  = ENC_WR_HOLD,
      ST_RD_WAIT  = ENC_RD_WAIT,
      ST_RD_HOLD  = ENC_RD_HOLD,
      ST_ISO_TAIL = ENC_ISO_TAIL
   } fe_state_t;

   localparam int MAX_RDDLY_LEN  = 15;
   localparam int MAX_ISOUT_HOLD = 7;

endpackage

// File: rtl/usb_reg_fe_burst_if.sv
// Host parallel-bus pins: the host (master) drives address, data and strobes; the front-end (slave) returns read data and output-enable.
interface usb_reg_fe_burst_if #(
   parameter int pADDR_WIDTH = 21,
   parameter int pDATA_WIDTH = 8
);
   logic [pADDR_WIDTH-1:0] usb_addr;
   logic [pDATA_WIDTH-1:0] usb_din;
   logic [pDATA_WIDTH-1:0] usb_dout;
   logic                   usb_isout;
   logic                   usb_rdn;
   logic                   usb_wrn;
   logic                   usb_cen;

   modport master (
      output usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen,
      input  usb_dout, usb_isout
   );

   modport slave (
      input  usb_addr, usb_din, usb_rdn, usb_wrn, usb_cen,
      output usb_dout, usb_isout
   );
endinterface

// File: rtl/usb_fe_strobe_sync.sv
// Input stage: registers address, data and strobes once. With USB_FE_SYNC_EN a 2-flop
// synchronizer sits ahead of it, and address/data are delayed to stay aligned with the strobes.
module usb_fe_strobe_sync #(
   parameter int pADDR_WIDTH = 21,
   parameter int pDATA_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [pADDR_WIDTH-1:0] usb_addr,
   input  logic [pDATA_WIDTH-1:0] usb_din,
   input  logic                   usb_rdn,
   input  logic                   usb_wrn,
   input  logic                   usb_cen,
   output logic [pADDR_WIDTH-1:0] addr_r,
   output logic [pDATA_WIDTH-1:0] din_r,
   output logic                   rdn_r,
   output logic                   wrn_r,
   output logic                   cen_r
);
   logic [pADDR_WIDTH-1:0] addr_in;
   logic [pDATA_WIDTH-1:0] din_in;
   logic [2:0]             strb_in;

`ifdef USB_FE_SYNC_EN
   logic [2:0]             strb_s1, strb_s2;
   logic [pADDR_WIDTH-1:0] addr_s1, addr_s2;
   logic [pDATA_WIDTH-1:0] din_s1, din_s2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         strb_s1 <= 3'b111;
         strb_s2 <= 3'b111;
         addr_s1 <= '0;
         addr_s2 <= '0;
         din_s1  <= '0;
         din_s2  <= '0;
      end else begin
         strb_s1 <= {usb_rdn, usb_wrn, usb_cen};
         strb_s2 <= strb_s1;
         addr_s1 <= usb_addr;
         addr_s2 <= addr_s1;
         din_s1  <= usb_din;
         din_s2  <= din_s1;
      end
   end

   assign strb_in = strb_s2;
   assign addr_in = addr_s2;
   assign din_in  = din_s2;
`else
   assign strb_in = {usb_rdn, usb_wrn, usb_cen};
   assign addr_in = usb_addr;
   assign din_in  = usb_din;
`endif

   // Strobes idle high so reset looks like an idle bus.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         {rdn_r, wrn_r, cen_r} <= 3'b111;
         addr_r                <= '0;
         din_r                 <= '0;
      end else begin
         {rdn_r, wrn_r, cen_r} <= strb_in;
         addr_r                <= addr_in;
         din_r                 <= din_in;
      end
   end
endmodule

// File: rtl/usb_reg_fe_burst.sv
// Host-bus register front-end: turns level strobes into one-cycle reg_read/reg_write pulses,
// with delayed read capture, burst byte-count and sticky protocol error. USB_FE_SYNC_EN adds a strobe synchronizer.
module usb_reg_fe_burst
   import usb_fe_pkg::*;
#(
   parameter int pADDR_WIDTH    = 21,
   parameter int pBYTECNT_SIZE  = 7,
   parameter int pDATA_WIDTH    = 8,
   parameter int pREG_RDDLY_LEN = 3,
   parameter int pISOUT_HOLD    = 2
) (
   input  logic                             usb_clk,
   input  logic                             rst,
   usb_reg_fe_burst_if.slave                host,
   input  logic                             burst_en,
   output logic [pADDR_WIDTH-pBYTECNT_SIZE-1:0] reg_address,
   output logic [pBYTECNT_SIZE-1:0]         reg_bytecnt,
   output logic [pDATA_WIDTH-1:0]           reg_datao,
   input  logic [pDATA_WIDTH-1:0]           reg_datai,
   output logic                             reg_read,
   output logic                             reg_write,
   output logic                             reg_addrvalid,
   output logic                             protocol_err
);
   localparam logic [3:0] RDDLY_LOAD = 4'(pREG_RDDLY_LEN);
   localparam logic [3:0] ISO_LOAD   = (pISOUT_HOLD > 0) ? 4'(pISOUT_HOLD - 1) : 4'd0;

   if (pREG_RDDLY_LEN < 1 || pREG_RDDLY_LEN > MAX_RDDLY_LEN || pISOUT_HOLD < 0 ||
       pISOUT_HOLD > MAX_ISOUT_HOLD || (pDATA_WIDTH != 8 && pDATA_WIDTH != 16)) begin : g_bad_param
      $error("usb_reg_fe_burst: parameter out of range");
   end

   logic [pADDR_WIDTH-1:0]   addr_r;
   logic [pDATA_WIDTH-1:0]   din_r;
   logic                     rdn_r, wrn_r, cen_r;
   fe_state_t                state, state_nxt;
   logic [3:0]               cnt, cnt_nxt;
   logic [pBYTECNT_SIZE-1:0] bcnt, addr_lo;
   logic [pDATA_WIDTH-1:0]   dout_q;
   logic                     wr_req, rd_req, bad_req;
   logic                     start_wr, start_rd, capture, complete, err_set;

   usb_fe_strobe_sync #(.pADDR_WIDTH(pADDR_WIDTH), .pDATA_WIDTH(pDATA_WIDTH)) u_sync (
      .clk(usb_clk), .rst(rst),
      .usb_addr(host.usb_addr), .usb_din(host.usb_din),
      .usb_rdn(host.usb_rdn), .usb_wrn(host.usb_wrn), .usb_cen(host.usb_cen),
      .addr_r(addr_r), .din_r(din_r), .rdn_r(rdn_r), .wrn_r(wrn_r), .cen_r(cen_r)
   );

   assign wr_req  = ~cen_r & ~wrn_r &  rdn_r;
   assign rd_req  = ~cen_r & ~rdn_r &  wrn_r;
   assign bad_req = ~cen_r & ~rdn_r & ~wrn_r;

   always_ff @(posedge usb_clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      start_wr  = 1'b0;
      start_rd  = 1'b0;
      capture   = 1'b0;
      complete  = 1'b0;
      err_set   = 1'b0;
      case (state)
         // The output-enable tail accepts a new strobe exactly like IDLE.
         ST_IDLE, ST_ISO_TAIL: begin
            if (wr_req) begin
               start_wr  = 1'b1;
               state_nxt = ST_WR_HOLD;
            end else if (rd_req) begin
               start_rd  = 1'b1;
               cnt_nxt   = RDDLY_LOAD;
               state_nxt = ST_RD_WAIT;
            end else begin
               err_set = bad_req;
               if (state == ST_ISO_TAIL) begin
                  if (cnt == 4'd0) state_nxt = ST_IDLE;
                  else             cnt_nxt   = cnt - 4'd1;
               end
            end
         end
         ST_WR_HOLD: begin
            if (wrn_r || cen_r) begin
               complete  = 1'b1;
               state_nxt = ST_IDLE;
            end
         end
         ST_RD_WAIT: begin
            if (cnt == 4'd0) begin
               capture   = 1'b1;
               state_nxt = ST_RD_HOLD;
            end else if (rdn_r || cen_r) begin
               state_nxt = ST_IDLE;
            end else begin
               cnt_nxt = cnt - 4'd1;
            end
         end
         ST_RD_HOLD: begin
            if (rdn_r) begin
               complete = 1'b1;
               if (pISOUT_HOLD == 0) begin
                  state_nxt = ST_IDLE;
               end else begin
                  cnt_nxt   = ISO_LOAD;
                  state_nxt = ST_ISO_TAIL;
               end
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge usb_clk or posedge rst) begin
      if (rst) begin
         reg_write    <= 1'b0;
         reg_read     <= 1'b0;
         reg_address  <= '0;
         addr_lo      <= '0;
         reg_datao    <= '0;
         dout_q       <= '0;
         protocol_err <= 1'b0;
         bcnt         <= '0;
      end else begin
         reg_write <= start_wr;
         reg_read  <= start_rd;
         if (start_wr || start_rd) begin
            reg_address <= addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE];
            addr_lo     <= addr_r[pBYTECNT_SIZE-1:0];
         end
         if (start_wr) reg_datao <= din_r;
         if (capture)  dout_q    <= reg_datai;
         if (err_set)  protocol_err <= 1'b1;
         // A burst continues only while enabled and on the same register.
         if (!burst_en) begin
            bcnt <= '0;
         end else if (start_wr || start_rd) begin
            if (addr_r[pADDR_WIDTH-1:pBYTECNT_SIZE] != reg_address) bcnt <= '0;
         end else if (complete) begin
            bcnt <= bcnt + pBYTECNT_SIZE'(1);
         end
      end
   end

   assign reg_bytecnt    = addr_lo + bcnt;
   assign reg_addrvalid  = (state == ST_WR_HOLD) || (state == ST_RD_WAIT) || (state == ST_RD_HOLD);
   assign host.usb_dout  = dout_q;
   assign host.usb_isout = ~rdn_r || (state == ST_RD_WAIT) || (state == ST_RD_HOLD) ||
                           (state == ST_ISO_TAIL);
endmodule

// File: tb/tb_usb_reg_fe_burst.sv
// Directed + randomized bench for usb_reg_fe_burst against a transaction-level model of the host bus rules.
module tb_usb_reg_fe_burst;
   localparam int AW    = 21;
   localparam int BC    = 7;
   localparam int DW    = 8;
   localparam int RDDLY = 3;
   localparam int ISO   = 2;
`ifdef USB_FE_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif

   logic           usb_clk = 1'b0;
   logic           rst;
   logic           burst_en;
   logic [DW-1:0]  reg_datai, reg_datao;
   logic [AW-BC-1:0] reg_address;
   logic [BC-1:0]  reg_bytecnt;
   logic           reg_read, reg_write, reg_addrvalid, protocol_err;

   int total = 0;
   int bad   = 0;

   // Model: burst count, last register selected, last captured read data, error flag.
   int            m_cnt;
   int            m_prev_sel;
   logic [DW-1:0] m_dout;
   logic          m_err;

   usb_reg_fe_burst_if #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) host ();

   usb_reg_fe_burst #(
      .pADDR_WIDTH(AW), .pBYTECNT_SIZE(BC), .pDATA_WIDTH(DW),
      .pREG_RDDLY_LEN(RDDLY), .pISOUT_HOLD(ISO)
   ) dut (
      .usb_clk(usb_clk), .rst(rst), .host(host), .burst_en(burst_en),
      .reg_address(reg_address), .reg_bytecnt(reg_bytecnt), .reg_datao(reg_datao),
      .reg_datai(reg_datai), .reg_read(reg_read), .reg_write(reg_write),
      .reg_addrvalid(reg_addrvalid), .protocol_err(protocol_err)
   );

   always #5 usb_clk = ~usb_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge usb_clk);
      #1;
   endtask

   task automatic pins_idle();
      host.usb_cen = 1'b1;
      host.usb_rdn = 1'b1;
      host.usb_wrn = 1'b1;
   endtask

   task automatic model_reset();
      m_cnt      = 0;
      m_prev_sel = 0;
      m_dout     = '0;
      m_err      = 1'b0;
   endtask

   task automatic model_start(input logic [AW-1:0] a, output logic [BC-1:0] bc);
      int sel;
      sel = int'(a) / (2 ** BC);
      if (!burst_en || sel != m_prev_sel) m_cnt = 0;
      m_prev_sel = sel;
      bc = BC'((int'(a) % (2 ** BC) + m_cnt) % (2 ** BC));
   endtask

   task automatic model_complete();
      if (burst_en) m_cnt = (m_cnt + 1) % (2 ** BC);
   endtask

   task automatic chk_zero(input string tag);
      chk(tag, 64'({reg_address, reg_bytecnt, reg_datao, host.usb_dout, reg_read, reg_write,
                    reg_addrvalid, host.usb_isout, protocol_err}), 64'd0);
   endtask

   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
      logic [BC-1:0] exp_bc;
      int npw, npr, pos;
      model_start(a, exp_bc);
      host.usb_addr = a;
      host.usb_din  = d;
      host.usb_cen  = 1'b0;
      host.usb_wrn  = 1'b0;
      npw = 0; npr = 0; pos = -1;
      for (int k = 1; k <= hold + LAT + 1; k++) begin
         tick();
         if (k == hold) pins_idle();
         if (reg_read) npr++;
         if (reg_write) begin
            npw++;
            if (pos < 0) begin
               pos = k;
               chk("wr_address", 64'(reg_address), 64'(int'(a) / (2 ** BC)));
               chk("wr_bytecnt", 64'(reg_bytecnt), 64'(exp_bc));
               chk("wr_datao", 64'(reg_datao), 64'(d));
               chk("wr_addrvalid", 64'(reg_addrvalid), 64'd1);
            end
         end
      end
      model_complete();
      chk("wr_pulses", 64'(npw), 64'd1);
      chk("wr_latency", 64'(pos), 64'(LAT));
      chk("wr_no_read", 64'(npr), 64'd0);
      chk("wr_err_flag", 64'(protocol_err), 64'(m_err));
   endtask

   // A read completes only if the strobe is still low when the capture delay expires.
   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] di, input int hold);
      logic [BC-1:0] exp_bc;
      int  npr, npw, pos, rise;
      bit  full;
      model_start(a, exp_bc);
      full = (hold > RDDLY);
      rise = hold + LAT - 1;
      reg_datai     = di;
      host.usb_addr = a;
      host.usb_cen  = 1'b0;
      host.usb_rdn  = 1'b0;
      npr = 0; npw = 0; pos = -1;
      for (int k = 1; k <= hold + LAT + 3; k++) begin
         tick();
         if (k == hold) pins_idle();
         if (reg_write) npw++;
         if (reg_read) begin
            npr++;
            if (pos < 0) begin
               pos = k;
               chk("rd_address", 64'(reg_address), 64'(int'(a) / (2 ** BC)));
               chk("rd_bytecnt", 64'(reg_bytecnt), 64'(exp_bc));
            end
         end
         if (full && k == LAT + 1)         chk("rd_isout_wait", 64'(host.usb_isout), 64'd1);
         if (full && k == LAT + RDDLY)     chk("rd_dout_before", 64'(host.usb_dout), 64'(m_dout));
         if (full && k == LAT + RDDLY + 1) chk("rd_dout", 64'(host.usb_dout), 64'(di));
         if (full && k == rise + 2)        chk("rd_isout_tail", 64'(host.usb_isout), 64'd1);
         if (full && k == rise + 3)        chk("rd_isout_off", 64'(host.usb_isout), 64'd0);
      end
      if (full) begin
         m_dout = di;
         model_complete();
      end else begin
         chk("abort_dout_kept", 64'(host.usb_dout), 64'(m_dout));
         chk("abort_isout_off", 64'(host.usb_isout), 64'd0);
      end
      chk("rd_pulses", 64'(npr), 64'd1);
      chk("rd_latency", 64'(pos), 64'(LAT));
      chk("rd_no_write", 64'(npw), 64'd0);
   endtask

   task automatic do_bad(input int hold);
      int np;
      np = 0;
      host.usb_cen = 1'b0;
      host.usb_rdn = 1'b0;
      host.usb_wrn = 1'b0;
      for (int k = 1; k <= hold + LAT + 1; k++) begin
         tick();
         if (k == hold) pins_idle();
         if (reg_read || reg_write) np++;
      end
      m_err = 1'b1;
      chk("perr_no_pulse", 64'(np), 64'd0);
      chk("perr_flag", 64'(protocol_err), 64'(m_err));
   endtask

   initial begin
      logic [AW-1:0] a;
      int op, sel, lo;
      rst = 1'b1;
      burst_en = 1'b0;
      reg_datai = '0;
      host.usb_addr = '0;
      host.usb_din  = '0;
      pins_idle();
      model_reset();
      tick();
      tick();
      chk_zero("reset_state");
      rst = 1'b0;
      tick();
      chk_zero("idle_after_reset");

      do_write(21'h000285, 8'hA5, 4);
      do_read(21'h000285, 8'h3C, 9);

      burst_en = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) do_write(21'h000300, DW'($urandom), 2);
      burst_en = 1'b0;
      m_cnt = 0;
      tick();
      burst_en = 1'b1;
      tick();
      do_write(21'h00037F, DW'($urandom), 2);
      do_write(21'h00037F, DW'($urandom), 2);

      do_read(21'h00037F, 8'h3C, 8);
      do_read(21'h00037F, 8'h99, 2);
      do_write(21'h00037F, DW'($urandom), 1);

      do_bad(3);
      do_write(21'h000285, 8'h5A, 2);
      do_read(21'h000285, 8'hC3, 6);

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 4) == 0) begin
            burst_en = ~burst_en;
            if (!burst_en) m_cnt = 0;
            tick();
         end
         op  = int'($urandom_range(0, 3));
         sel = int'($urandom_range(2, 4));
         lo  = int'($urandom_range(0, 127));
         a   = AW'(sel * (2 ** BC) + lo);
         case (op)
            0, 1:    do_write(a, DW'($urandom), int'($urandom_range(1, 5)));
            2:       do_read(a, DW'($urandom), int'($urandom_range(5, 9)));
            default: do_read(a, DW'($urandom), int'($urandom_range(1, 2)));
         endcase
         repeat ($urandom_range(0, 2)) tick();
      end

      host.usb_addr = 21'h000512;
      host.usb_din  = 8'h5A;
      host.usb_cen  = 1'b0;
      host.usb_wrn  = 1'b0;
      repeat (LAT + 1) tick();
      chk("pre_rst_addrvalid", 64'(reg_addrvalid), 64'd1);
      #2 rst = 1'b1;
      #1;
      chk_zero("rst_in_wr_hold");
      pins_idle();
      model_reset();
      burst_en = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_zero("after_rst_release");
      do_write(21'h000285, 8'h11, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/usb_reg_fe_burst.md
Name: usb_reg_fe_burst

Overview:
- Parametrised next-generation host-bus register front-end for CW305-class targets.
- Converts level-style host strobes (usb_rdn/usb_wrn/usb_cen) into single-cycle reg_read/reg_write pulses, using an access state machine.
- Adds a configurable data width, a counted read-capture delay, burst byte-count auto-increment and a sticky protocol-error flag.
- Sits between the host parallel bus pins and the project register block.

Parameters:
- pADDR_WIDTH, 21: host address width.
- pBYTECNT_SIZE, 7: low address bits used as the byte count; upper bits select the register.
- pDATA_WIDTH, 8: data bus width, 8 or 16.
- pREG_RDDLY_LEN, 3: cycles from the reg_read pulse to the reg_datai capture, 1..15.
- pISOUT_HOLD, 2: cycles usb_isout stays high after the read ends, 0..7.

Ports:
- usb_clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- usb_din  in  pDATA_WIDTH  host write data.
- usb_dout  out  pDATA_WIDTH  host read data (registered).
- usb_isout  out  1  data-bus output-enable.
- usb_addr  in  pADDR_WIDTH  host address.
- usb_rdn / usb_wrn / usb_cen  in  1 each  active-low strobes.
- burst_en  in  1  enables byte-count auto-increment.
- reg_address  out  pADDR_WIDTH-pBYTECNT_SIZE  latched register select.
- reg_bytecnt  out  pBYTECNT_SIZE  effective byte count.
- reg_datao  out  pDATA_WIDTH  latched write data.
- reg_datai  in  pDATA_WIDTH  register read data.
- reg_read  out  1  one-cycle read pulse.
- reg_write  out  1  one-cycle write pulse.
- reg_addrvalid  out  1  high while an access is in progress.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock, usb_clk. Reset rst is asynchronous and active-high.
- Reset: all outputs reset to 0, the FSM returns to IDLE, and the burst counter and protocol_err clear. A reset in mid-access aborts the access with no pulse.
- Input stage: usb_addr, usb_din, rdn, wrn and cen are registered once (the _r signals). All decisions use the _r signals.
- FSM states: IDLE, WR_HOLD, RD_WAIT, RD_HOLD, ISO_TAIL.
- IDLE, write start (cen_r=0, wrn_r=0, rdn_r=1):
  - Latch the address and din_r.
  - reg_write=1 for exactly one cycle; reg_addrvalid=1.
  - Go to WR_HOLD.
  - Latency: pin wrn low at edge N gives reg_write high during cycle N+2.
- IDLE, read start (cen_r=0, rdn_r=0, wrn_r=1):
  - Latch the address.
  - reg_read=1 for one cycle.
  - Load the delay counter with pREG_RDDLY_LEN and go to RD_WAIT.
- IDLE, cen_r=0 with rdn_r=0 and wrn_r=0: set protocol_err (sticky until rst), issue no pulse, stay in IDLE.
- WR_HOLD: when wrn_r=1 or cen_r=1, go to IDLE, drop reg_addrvalid and apply the burst increment. No second pulse while wrn stays low.
- RD_WAIT: the counter decrements each cycle. At zero, usb_dout <= reg_datai and go to RD_HOLD.
- RD_WAIT abort: rdn_r=1 or cen_r=1 before zero goes to IDLE. usb_dout is not updated and there is no increment.
- RD_HOLD: usb_dout is held. On rdn_r=1, apply the increment and go to ISO_TAIL, or to IDLE if pISOUT_HOLD=0.
- ISO_TAIL: counts pISOUT_HOLD cycles, then goes to IDLE. A new strobe in ISO_TAIL is accepted as if in IDLE.
- usb_isout = ~rdn_r OR state in {RD_WAIT, RD_HOLD, ISO_TAIL}.
- Burst counter:
  - Width pBYTECNT_SIZE; reg_bytecnt = latched addr[pBYTECNT_SIZE-1:0] + burst counter, modulo 2^pBYTECNT_SIZE.
  - Increments on each completed access when burst_en=1.
  - Clears when an access starts with a register address different from the previous one, or when burst_en=0.
  - Wraps from 2^pBYTECNT_SIZE-1 to 0 silently.

Optional Feature:
- Macro USB_FE_SYNC_EN.
- When defined: a 2-flop synchronizer is inserted on rdn/wrn/cen ahead of the input stage, for an asynchronous host bus. All strobe latencies grow by 2 cycles. Address and data are sampled from the stage aligned with the synchronized strobes.
- When undefined: single register stage as described above.

Decomposition:
- Shared package usb_fe_pkg holds:
  - the FSM state enum (3-bit);
  - constants for the state encodings;
  - the maximum pREG_RDDLY_LEN and pISOUT_HOLD values for parameter checks.
- One natural sub-module: usb_fe_strobe_sync, i.e. the input stage plus the optional synchronizer, emitting the _r signals.

Test Plan:
- Single write, addr=0x000285, din=0xA5, wrn low 4 cycles -> reg_write high exactly 1 cycle (cycle N+2), reg_address=0x05, reg_bytecnt=0x05, reg_datao=0xA5.
- Single read, pREG_RDDLY_LEN=3, reg_datai=0x3C -> reg_read pulse at N+2, usb_dout=0x3C from N+6, usb_isout high until 2 cycles after rdn_r rises.
- Burst, burst_en=1, addr fixed 0x000300, 4 writes -> reg_bytecnt 0,1,2,3. Then 0x00037F plus 2 writes -> bytecnt 0x7F then 0x00 (wrap).
- rdn and wrn both low with cen low -> no pulses, protocol_err=1, remains 1 after legal accesses until rst.
- Read aborted (rdn high 1 cycle after reg_read, pREG_RDDLY_LEN=3) -> usb_dout keeps its prior value and the burst count is unchanged. Separately, rst asserted in WR_HOLD -> all outputs 0 immediately.
- With USB_FE_SYNC_EN defined, single write -> reg_write at N+4, value checks identical to the first scenario.
